// File: rtl/pipelined_seg_adder_if.sv
// Valid/ready bundle for the segmented adder: request side (operands) and
// response side (sum, carry, overflow).
interface pipelined_seg_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_seg_adder.sv
// Skewed carry-pipelined adder/subtractor: one SEG-bit segment is summed per
// stage, with elastic valid/ready flow control between stages.

module pipelined_seg_adder_stage #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o
);
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_d;
    logic             msb_cin;

    logic             vld_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, ovf_q;

    always_comb begin
        seg_sum = {1'b0, a_i[K*SEG +: SEG]} + {1'b0, b_i[K*SEG +: SEG]}
                + {{SEG{1'b0}}, c_i};
        s_d = s_i;
        s_d[K*SEG +: SEG] = seg_sum[SEG-1:0];
        // Carry into this segment's top bit; only the last stage's is the true MSB.
        msb_cin = a_i[K*SEG+SEG-1] ^ b_i[K*SEG+SEG-1] ^ seg_sum[SEG-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else if (ld_i) begin
            vld_q <= vld_i;
            // Bubbles leave the data registers untouched.
            if (vld_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                s_q   <= s_d;
                c_q   <= seg_sum[SEG];
                ovf_q <= msb_cin ^ seg_sum[SEG];
            end
        end
    end

    assign vld_o = vld_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign s_o   = s_q;
    assign c_o   = c_q;
    assign ovf_o = ovf_q;
endmodule

module pipelined_seg_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_seg_adder_if.slave  bus
);
    localparam bit BAD  = (SEG < 1) || (WIDTH < SEG) || ((WIDTH % ((SEG < 1) ? 1 : SEG)) != 0);
    localparam int NSEG = BAD ? 1 : WIDTH / SEG;

    generate
        if (BAD) begin : g_bad_params
            $error("pipelined_seg_adder: WIDTH must be a nonzero multiple of SEG>=1");
        end
    endgenerate

    // Index 0 is the input port; index k+1 is the output of stage k.
    logic [NSEG:0]            vld_pipe;
    logic [NSEG:0]            c_pipe;
    logic [NSEG:0][WIDTH-1:0] a_pipe;
    logic [NSEG:0][WIDTH-1:0] b_pipe;
    logic [NSEG:0][WIDTH-1:0] s_pipe;
    logic [NSEG-1:0]          ovf_s;
    logic [NSEG-1:0]          adv;
    logic [NSEG-1:0]          ld;

    assign vld_pipe[0] = bus.in_valid;
    assign a_pipe[0]   = bus.a;
    assign b_pipe[0]   = bus.sub ? ~bus.b : bus.b;
    assign s_pipe[0]   = '0;
    assign c_pipe[0]   = bus.sub | bus.cin;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_stage
            if (k == NSEG - 1) begin : g_last
                assign adv[k] = vld_pipe[k+1] && bus.out_ready;
            end else begin : g_mid
                assign adv[k] = vld_pipe[k+1] && (!vld_pipe[k+2] || adv[k+1]);
            end
            assign ld[k] = !vld_pipe[k+1] || adv[k];

            pipelined_seg_adder_stage #(
                .WIDTH (WIDTH),
                .SEG   (SEG),
                .K     (k)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (ld[k]),
                .vld_i (vld_pipe[k]),
                .a_i   (a_pipe[k]),
                .b_i   (b_pipe[k]),
                .s_i   (s_pipe[k]),
                .c_i   (c_pipe[k]),
                .vld_o (vld_pipe[k+1]),
                .a_o   (a_pipe[k+1]),
                .b_o   (b_pipe[k+1]),
                .s_o   (s_pipe[k+1]),
                .c_o   (c_pipe[k+1]),
                .ovf_o (ovf_s[k])
            );
        end
    endgenerate

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_pipe[NSEG];
    assign bus.sum       = s_pipe[NSEG];
    assign bus.cout      = c_pipe[NSEG];
    assign bus.ovf       = ovf_s[NSEG-1];
endmodule
